// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates an instruction-fetch port and a data port onto a
//                single registered-command data memory. One access occupies
//                three cycles (IDLE sample, CMD, RESP). The two requesters are
//                granted one at a time; requests are not queued.
//  Config      : ARB_RR_EN defined   -> round-robin on simultaneous requests
//                ARB_RR_EN undefined -> data port always wins (fixed priority)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // pipeline stalls
    output logic        i_stall,
    output logic        d_stall,
    // shared memory command
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        store_q, store_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q,    rd_d;
    logic        wr_q,    wr_d;
    logic        winner;

`ifdef ARB_RR_EN
    logic        last_grant_q, last_grant_d;
`endif

    // Choose which requester would be granted if the FSM samples this cycle.
    always_comb begin
        winner = OWNER_I;
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
            winner = (last_grant_q == OWNER_I) ? OWNER_D : OWNER_I;
`else
            winner = OWNER_D;
`endif
        end else if (d_req) begin
            winner = OWNER_D;
        end
    end

    // Next-state and next-command logic; everything holds unless changed.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        store_d = store_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = CMD;
                    owner_d = winner;
                    addr_d  = (winner == OWNER_D) ? d_addr : i_addr;
                    wdata_d = d_wdata;
                    store_d = (winner == OWNER_D) && d_we;
                    rd_d    = !((winner == OWNER_D) && d_we);
                    wr_d    = (winner == OWNER_D) && d_we;
`ifdef ARB_RR_EN
                    last_grant_d = winner;
`endif
                end
            end
            CMD: begin
                // command has been seen by memory at this edge; drop it
                state_d = RESP;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and command registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
            store_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

`ifdef ARB_RR_EN
    // Remember the last granted requester; starts at I so D wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWNER_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_memread  = rd_q;
    assign mem_memwrite = wr_q;

    // Completion and read data are decoded from state; memory data is valid in RESP.
    assign i_ack   = (state_q == RESP) && (owner_q == OWNER_I);
    assign d_ack   = (state_q == RESP) && (owner_q == OWNER_D);
    assign i_rdata = i_ack ? mem_rdata : 32'd0;
    assign d_rdata = (d_ack && !store_q) ? mem_rdata : 32'd0;

    // Stalls are forced low during reset so every output reads zero then.
    assign i_stall = i_req & ~i_ack & ~rst;
    assign d_stall = d_req & ~d_ack & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        i_stall;
    logic        d_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_rdata;

    int vec;
    int miss;

    logic [31:0] mem [0:255];

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .i_stall      (i_stall),
        .d_stall      (d_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory with registered read data
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem_memread ? mem[mem_addr[7:0]] : 32'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; i_addr = 32'd3; d_req = 1'b0;
        tick();
        tick();
        vec++; if (i_ack !== 1'b0) begin miss++; $display("FAIL rst_i_ack got %b want 0", i_ack); end
        vec++; if (d_ack !== 1'b0) begin miss++; $display("FAIL rst_d_ack got %b want 0", d_ack); end
        vec++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin miss++;
            $display("FAIL rst_cmd got rd=%b wr=%b want 0 0", mem_memread, mem_memwrite); end
        vec++; if (mem_addr !== 32'd0) begin miss++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        vec++; if (i_stall !== 1'b0) begin miss++; $display("FAIL rst_i_stall got %b want 0", i_stall); end
        i_req = 1'b0;
        rst = 1'b0;
        tick();
        vec++; if (mem_memread !== 1'b0) begin miss++; $display("FAIL idle_no_req got %b want 0", mem_memread); end
    endtask

    task automatic test_i_fetch();
        i_req = 1'b1; i_addr = 32'd5;
        #1;
        vec++; if (i_stall !== 1'b1) begin miss++; $display("FAIL fetch_stall0 got %b want 1", i_stall); end
        tick();
        vec++; if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== 32'd5) begin miss++;
            $display("FAIL fetch_cmd got rd=%b wr=%b addr=%h want 1 0 5", mem_memread, mem_memwrite, mem_addr); end
        vec++; if (i_ack !== 1'b0 || i_stall !== 1'b1) begin miss++;
            $display("FAIL fetch_cmd_ack got ack=%b stall=%b want 0 1", i_ack, i_stall); end
        tick();
        vec++; if (mem_memread !== 1'b0) begin miss++; $display("FAIL fetch_rd_clear got %b want 0", mem_memread); end
        vec++; if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin miss++;
            $display("FAIL fetch_ack got ack=%b data=%h want 1 deadbeef", i_ack, i_rdata); end
        vec++; if (i_stall !== 1'b0 || d_ack !== 1'b0) begin miss++;
            $display("FAIL fetch_resp got stall=%b d_ack=%b want 0 0", i_stall, d_ack); end
        i_req = 1'b0;
        tick();
        vec++; if (i_ack !== 1'b0 || i_rdata !== 32'd0) begin miss++;
            $display("FAIL fetch_after got ack=%b data=%h want 0 0", i_ack, i_rdata); end
    endtask

    task automatic test_d_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h12345678;
        tick();
        vec++; if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0 || mem_addr !== 32'd9 || mem_wdata !== 32'h12345678) begin miss++;
            $display("FAIL store_cmd got wr=%b rd=%b addr=%h wd=%h want 1 0 9 12345678", mem_memwrite, mem_memread, mem_addr, mem_wdata); end
        tick();
        vec++; if (mem_memwrite !== 1'b0 || d_ack !== 1'b1 || d_rdata !== 32'd0) begin miss++;
            $display("FAIL store_ack got wr=%b ack=%b data=%h want 0 1 0", mem_memwrite, d_ack, d_rdata); end
        d_req = 1'b0;
        tick();
        vec++; if (d_ack !== 1'b0 || mem_memwrite !== 1'b0) begin miss++;
            $display("FAIL store_after got ack=%b wr=%b want 0 0", d_ack, mem_memwrite); end
        d_req = 1'b1; d_we = 1'b0; d_wdata = 32'd0;
        tick();
        vec++; if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== 32'd9) begin miss++;
            $display("FAIL load_cmd got rd=%b wr=%b addr=%h want 1 0 9", mem_memread, mem_memwrite, mem_addr); end
        tick();
        vec++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678 || i_rdata !== 32'd0) begin miss++;
            $display("FAIL load_ack got ack=%b data=%h irdata=%h want 1 12345678 0", d_ack, d_rdata, i_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic exp_d;
        apply_reset();
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd9;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            vec++; if (mem_addr !== (exp_d ? 32'd9 : 32'd5) || mem_memread !== 1'b1) begin miss++;
                $display("FAIL arb_grant%0d got addr=%h rd=%b want %h 1", k, mem_addr, mem_memread, exp_d ? 32'd9 : 32'd5); end
            tick();
            vec++; if (d_ack !== exp_d || i_ack !== !exp_d) begin miss++;
                $display("FAIL arb_ack%0d got d=%b i=%b want %b %b", k, d_ack, i_ack, exp_d, !exp_d); end
            vec++; if (i_stall !== exp_d || d_stall !== !exp_d) begin miss++;
                $display("FAIL arb_stall%0d got i=%b d=%b want %b %b", k, i_stall, d_stall, exp_d, !exp_d); end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'h000000AA;
        tick();
        vec++; if (mem_memwrite !== 1'b1) begin miss++; $display("FAIL mid_cmd got %b want 1", mem_memwrite); end
        #1 rst = 1'b1;
        #1;
        vec++; if (mem_memwrite !== 1'b0 || mem_addr !== 32'd0 || d_ack !== 1'b0 || d_stall !== 1'b0) begin miss++;
            $display("FAIL mid_abort got wr=%b addr=%h ack=%b stall=%b want 0 0 0 0", mem_memwrite, mem_addr, d_ack, d_stall); end
        tick();
        vec++; if (d_ack !== 1'b0) begin miss++; $display("FAIL mid_no_ack got %b want 0", d_ack); end
        vec++; if (mem[20] !== 32'd0) begin miss++; $display("FAIL mid_no_write got %h want 0", mem[20]); end
        rst = 1'b0;
        tick();
        vec++; if (mem_memwrite !== 1'b1 || mem_addr !== 32'd20) begin miss++;
            $display("FAIL reissue_cmd got wr=%b addr=%h want 1 14", mem_memwrite, mem_addr); end
        tick();
        vec++; if (d_ack !== 1'b1) begin miss++; $display("FAIL reissue_ack got %b want 1", d_ack); end
        d_req = 1'b0;
        tick();
        vec++; if (mem[20] !== 32'h000000AA) begin miss++; $display("FAIL reissue_mem got %h want aa", mem[20]); end
    endtask

    task automatic test_req_drop();
        i_req = 1'b1; i_addr = 32'd5;
        tick();
        vec++; if (mem_memread !== 1'b1 || mem_addr !== 32'd5) begin miss++;
            $display("FAIL drop_cmd got rd=%b addr=%h want 1 5", mem_memread, mem_addr); end
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd9;
        tick();
        vec++; if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_ack !== 1'b0) begin miss++;
            $display("FAIL drop_ack got i=%b data=%h d=%b want 1 deadbeef 0", i_ack, i_rdata, d_ack); end
        vec++; if (mem_memread !== 1'b0) begin miss++; $display("FAIL drop_no_queue got %b want 0", mem_memread); end
        tick();
        vec++; if (i_ack !== 1'b0 || mem_memread !== 1'b0 || d_stall !== 1'b1) begin miss++;
            $display("FAIL drop_idle got iack=%b rd=%b dstall=%b want 0 0 1", i_ack, mem_memread, d_stall); end
        tick();
        vec++; if (mem_memread !== 1'b1 || mem_addr !== 32'd9) begin miss++;
            $display("FAIL drop_next_cmd got rd=%b addr=%h want 1 9", mem_memread, mem_addr); end
        tick();
        vec++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin miss++;
            $display("FAIL drop_next_ack got ack=%b data=%h want 1 12345678", d_ack, d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        vec = 0; miss = 0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        for (int a = 0; a < 256; a++) mem[a] = 32'd0;
        mem[5] = 32'hDEADBEEF;
        test_reset();
        test_i_fetch();
        test_d_store_load();
        test_arbitration();
        test_reset_mid_access();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

`default_nettype wire
